// File: rtl/step_seq_pkg.sv
// Shared types and default sizing for the step sequencer.
package step_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_LAST  = 15;

endpackage

// File: rtl/step_inc.sv
// WIDTH-bit ripple-carry incrementer built from full-adder cells (b = 0, carry-in = 1).
module step_inc #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    localparam logic B = 1'b0;
    assign sum[i] = a[i] ^ B ^ carry[i];
    // The top cell's carry-out is never formed, so the increment wraps modulo 2**WIDTH.
    if (i < WIDTH - 1) begin : g_carry
      assign carry[i+1] = (a[i] & B) | (a[i] & carry[i]) | (B & carry[i]);
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Falling-edge step sequencer (IDLE/RUN) with stall, abort and optional auto-restart.
// Optional load/load_val ports are compiled in with STEP_SEQ_LOAD_EN.
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int LAST         = DEFAULT_LAST,
  parameter bit AUTO_RESTART = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             abort,
`ifdef STEP_SEQ_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`endif
  output logic [WIDTH-1:0] step,
  output logic             running,
  output logic             last_step,
  output logic             done
);

  if (WIDTH < 1 || WIDTH > 31 || LAST <= 0 || LAST >= (1 << WIDTH)) begin : g_param_check
    $error("step_sequencer: LAST must satisfy 0 < LAST < 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_plus1;

  step_inc #(.WIDTH(WIDTH)) u_step_inc (
    .a   (step_q),
    .sum (step_plus1)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    step_d  = step_q;
    done_d  = 1'b0;

    if (abort) begin
      state_d = IDLE;
      step_d  = '0;
`ifdef STEP_SEQ_LOAD_EN
    end else if (load) begin
      state_d = RUN;
      step_d  = (load_val > LAST_V) ? LAST_V : load_val;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            step_d  = '0;
          end
        end
        RUN: begin
          if (stall) begin
            step_d = step_q;
          end else if (step_q == LAST_V) begin
            done_d  = 1'b1;
            step_d  = '0;
            state_d = AUTO_RESTART ? RUN : IDLE;
          end else begin
            step_d = step_plus1;
          end
        end
        default: begin
          state_d = IDLE;
          step_d  = '0;
        end
      endcase
    end
  end

  // Reset is synchronous and overrides every other input; progress is discarded without done.
  always_ff @(negedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign step      = step_q;
  assign running   = (state_q == RUN);
  assign last_step = running && (step_q == LAST_V);
  assign done      = done_q;

endmodule
